inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch -- in-order instruction fetch unit with a small instruction buffer.
//
// Issues 4-byte-aligned fetch requests to instruction memory and queues the
// returned words for the decode controller. Each request reserves a buffer slot
// at handshake time, so the slot already holds the PC of that request when its
// response arrives. A redirect flushes the buffer and turns every outstanding
// request into a drop credit, so stale responses are discarded as they arrive.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req_valid/addr/ready    fetch request handshake (addr 4-byte aligned)
//   imem_resp_valid/data         in-order instruction responses
//   redirect_valid/pc            new-PC request (branch, jump, trap, xRET)
//   inst_valid/inst/inst_pc      buffer head presented to decode
//   inst_ready                   decode consumes the head this cycle
//   fetch_misaligned             last redirect target had pc[1:0] != 0
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;              // extra wrap bit tells full from empty
  localparam int DW = $clog2(2*DEPTH + 1); // drop counter reaches 2*DEPTH

  // Pointer order: r_head <= r_wr <= r_alloc (modulo wrap).
  //   [r_head, r_wr)  : filled entries (occupancy)
  //   [r_wr, r_alloc) : reserved for outstanding requests
  logic [63:0]   r_pc;
  logic [PW-1:0] r_head, r_wr, r_alloc;
  logic [DW-1:0] r_drop;
  logic          r_misal;
  logic [63:0]   r_pcm [DEPTH];
  logic [31:0]   r_dat [DEPTH];

  logic [PW-1:0] w_out, w_used;
  logic [DW-1:0] w_inflight;
  logic          w_req_fire, w_drop_dec, w_resp_out, w_enq, w_deq;

  assign w_out      = r_alloc - r_wr;
  assign w_used     = r_alloc - r_head;
  assign w_inflight = r_drop + DW'(w_out);

  // Besides the buffer credit, also cap drops + outstanding at 2*DEPTH so that
  // back-to-back redirects can never overflow the drop counter.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (w_used < PW'(DEPTH)) &&
                          (w_inflight < DW'(2*DEPTH));
  assign imem_req_addr  = r_pc;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_drop_dec = imem_resp_valid && (r_drop != '0);
  // Response belonging to a live request; with nothing owed it is ignored.
  assign w_resp_out = imem_resp_valid && (r_drop == '0) && (w_out != '0);
  assign w_enq      = w_resp_out && !redirect_valid;

  assign inst_valid       = (r_wr != r_head);
  assign inst             = r_dat[r_head[AW-1:0]];
  assign inst_pc          = r_pcm[r_head[AW-1:0]];
  assign w_deq            = inst_valid && inst_ready;
  assign fetch_misaligned = r_misal;

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_pcm[r_alloc[AW-1:0]] <= r_pc;
    if (w_enq)      r_dat[r_wr[AW-1:0]]    <= imem_resp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_wr    <= '0;
      r_alloc <= '0;
      r_drop  <= '0;
      r_misal <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[63:2], 2'b00};
      r_head  <= '0;
      r_wr    <= '0;
      r_alloc <= '0;
      r_misal <= |redirect_pc[1:0];
      // Everything still owed becomes a drop, minus the response consumed in
      // this very cycle (whether it was a drop or an outstanding one).
      r_drop  <= r_drop - DW'(w_drop_dec) + DW'(w_out) - DW'(w_resp_out)
                 + DW'(w_req_fire);
    end else begin
      if (w_req_fire) begin
        r_pc    <= r_pc + 64'd4;
        r_alloc <= r_alloc + PW'(1);
      end
      if (w_enq) r_wr   <= r_wr + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      r_drop <= r_drop - DW'(w_drop_dec);
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready, fetch_misaligned;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  inst_fetch #(.RESET_PC(64'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_misaligned(fetch_misaligned)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [63:0] pc, input logic [31:0] ins);
    exp_t e; e.pc = pc; e.ins = ins; sb.push_back(e);
  endtask

  // Memory model: in-order, 1-cycle minimum latency, responses gated by resp_en.
  logic [63:0] pend[$];
  logic        resp_en = 1'b1;
  int          n_acc = 0;
  always @(posedge clk) begin
    if (rst) pend.delete();
    else begin
      if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        n_acc++;
      end
    end
  end
  always @(negedge clk) begin
    #1;
    imem_resp_valid = resp_en && !rst && (pend.size() > 0);
    imem_resp_data  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
  end

  // Monitor: compares each instruction decode actually takes.
  always @(negedge clk) begin
    #2;
    if (!rst && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", {32'h0, inst}, {32'h0, e.ins});
      end
    end
  end

  // Offer requests until n more are accepted; returns at a negedge with ready low.
  task automatic accept_n(input int n);
    int target, cyc;
    target = n_acc + n;
    cyc = 0;
    imem_req_ready = 1'b1;
    while (n_acc < target && cyc < 60) begin
      @(negedge clk); cyc++;
    end
    imem_req_ready = 1'b0;
    if (n_acc < target) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", n_acc, target);
    end
  endtask

  int a0;
  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_misaligned", {63'h0, fetch_misaligned}, 64'h0);
    chk("rst_addr", imem_req_addr, 64'h0);

    // Straight-line fetch after reset
    @(negedge clk);
    rst = 1'b0; inst_ready = 1'b1;
    #2;
    chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("first_req_addr", imem_req_addr, 64'h0);
    expect_inst(64'h0, 32'h13579BDF);
    expect_inst(64'h4, 32'h13579BDB);
    expect_inst(64'h8, 32'h13579BD7);
    expect_inst(64'hC, 32'h13579BD3);
    accept_n(4);
    repeat (5) @(negedge clk);

    // Decode stalled: credit limit, then one dequeue frees one slot
    inst_ready = 1'b0; a0 = n_acc; imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("stall_accepts", 64'(n_acc - a0), 64'd4);
    chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
    expect_inst(64'h10, 32'h13579BCF);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("one_more_accept", 64'(n_acc - a0), 64'd5);
    chk("refull_req_valid", {63'h0, imem_req_valid}, 64'h0);
    imem_req_ready = 1'b0;
    expect_inst(64'h14, 32'h13579BCB);
    expect_inst(64'h18, 32'h13579BC7);
    expect_inst(64'h1C, 32'h13579BC3);
    expect_inst(64'h20, 32'h13579BFF);
    inst_ready = 1'b1;
    repeat (8) @(negedge clk);

    // Redirect with 3 outstanding
    resp_en = 1'b0;
    accept_n(3);
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    #2;
    chk("redir_cycle_req_valid", {63'h0, imem_req_valid}, 64'h0);
    @(negedge clk);
    redirect_valid = 1'b0; resp_en = 1'b1;
    #2;
    chk("redir_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("redir_addr", imem_req_addr, 64'h80);
    expect_inst(64'h80, 32'h13579B5F);
    accept_n(1);
    repeat (8) @(negedge clk);

    // Redirect coinciding with a response; misaligned target
    resp_en = 1'b0;
    accept_n(3);
    resp_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("misaligned_set", {63'h0, fetch_misaligned}, 64'h1);
    chk("aligned_addr", imem_req_addr, 64'h100);
    expect_inst(64'h100, 32'h13579ADF);
    accept_n(1);
    repeat (8) @(negedge clk);
    chk("misaligned_held", {63'h0, fetch_misaligned}, 64'h1);

    // Two redirects before the drops drain
    resp_en = 1'b0;
    accept_n(2);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("misaligned_clear", {63'h0, fetch_misaligned}, 64'h0);
    chk("addr_200", imem_req_addr, 64'h200);
    accept_n(2);
    redirect_valid = 1'b1; redirect_pc = 64'h300;
    @(negedge clk);
    redirect_valid = 1'b0; resp_en = 1'b1;
    expect_inst(64'h300, 32'h135798DF);
    accept_n(1);
    repeat (12) @(negedge clk);
    chk("drain_idle", {63'h0, inst_valid}, 64'h0);

    // Reset with requests in flight
    resp_en = 1'b0;
    accept_n(2);
    rst = 1'b1;
    #2;
    chk("midrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("midrst_inst_valid", {63'h0, inst_valid}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0; resp_en = 1'b1;
    #2;
    chk("postrst_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("postrst_addr", imem_req_addr, 64'h0);
    expect_inst(64'h0, 32'h13579BDF);
    accept_n(1);
    repeat (6) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
